// File: rtl/cmd_proc_pkg.sv
// Shared opcodes, per-opcode argument counts and the command FSM state type.
package cmd_proc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_EXEC,
    ST_SNAP,
    ST_TX_WAIT,
    ST_TX_PULSE
  } state_t;

  localparam logic [7:0] OP_VERSION = 8'h00;
  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] OP_TOGGLE  = 8'h03;
  localparam logic [7:0] OP_DUMP    = 8'h0A;
  localparam logic [7:0] OP_PLL     = 8'h0D;
  localparam logic [7:0] OP_CLR_ERR = 8'h0E;

  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_WRITE:            return 2'd2;
      OP_READ, OP_TOGGLE:  return 2'd1;
      default:             return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_tx_seq.sv
// Sends count bytes through a busy/start transmitter; byte_data must present the byte at index.
module byte_tx_seq #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic [7:0]    byte_data,
  input  logic          tx_busy,
  output logic [CW-1:0] index,
  output logic          done,
  output logic          tx_start,
  output logic [7:0]    tx_data
);

  logic          active_q, active_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;

  always_comb begin
    active_d   = active_q;
    pulse_d    = pulse_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    if (start) begin
      active_d   = 1'b1;
      pulse_d    = 1'b0;
      idx_d      = '0;
      cnt_d      = count;
      tx_start_d = 1'b0;
    end else if (active_q && !pulse_q && !tx_busy) begin
      tx_start_d = 1'b1;
      tx_data_d  = byte_data;
      pulse_d    = 1'b1;
    end else if (active_q && pulse_q) begin
      // tx_busy is not looked at here, so the strobe cycle ignores it
      tx_start_d = 1'b0;
      pulse_d    = 1'b0;
      idx_d      = idx_q + CW'(1);
      if (done) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q   <= 1'b0;
      pulse_q    <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      active_q   <= active_d;
      pulse_q    <= pulse_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign done     = active_q && pulse_q && (idx_q == cnt_q - CW'(1));
  assign index    = idx_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: rtl/cmd_processor_p.sv
// Byte-command processor: config registers, toggle flags, histogram dump and PLL/timeout control.
module cmd_processor_p
  import cmd_proc_pkg::*;
#(
  parameter logic [7:0]         VERSION  = 8'd24,
  parameter int                 NREGS    = 8,
  parameter int                 NFLAGS   = 8,
  parameter int                 NWORDS   = 34,
  parameter logic [NREGS*8-1:0] REG_INIT = '0,
  parameter int                 TIMEOUT  = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic [NWORDS*32-1:0]  hist_in,
  output logic                  hist_reset,
  output logic [NREGS*8-1:0]    regs_out,
  output logic [NFLAGS-1:0]     flags_out,
  output logic                  update_pll,
  output logic                  err_timeout,
  output state_t                dbg_state
);

  localparam int NBYTES = NWORDS * 4;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [7:0]           op_q, op_d;
  logic [1:0]           need_q, need_d;
  logic                 arg_idx_q, arg_idx_d;
  logic [1:0][7:0]      args_q, args_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 err_q, err_d;
  logic [NREGS*8-1:0]   regs_q, regs_d;
  logic [NFLAGS-1:0]    flags_q, flags_d;
  logic [NWORDS*32-1:0] snap_q, snap_d;
  logic                 hist_reset_q, hist_reset_d;
  logic                 update_pll_q, update_pll_d;
  logic [7:0]           reg_rd;
  logic                 seq_start;
  logic [CW-1:0]        seq_count;
  logic [CW-1:0]        seq_index;
  logic                 seq_done;

  always_comb begin
    reg_rd = 8'h00;
    for (int i = 0; i < NREGS; i++)
      if (int'(args_q[0]) == i) reg_rd = regs_q[i*8 +: 8];
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    need_d       = need_q;
    arg_idx_d    = arg_idx_q;
    args_d       = args_q;
    timer_d      = timer_q;
    err_d        = err_q;
    regs_d       = regs_q;
    flags_d      = flags_q;
    snap_d       = snap_q;
    hist_reset_d = 1'b0;
    update_pll_d = 1'b0;
    seq_start    = 1'b0;
    seq_count    = '0;
    case (state_q)
      ST_IDLE: if (rx_ready) begin
        op_d      = rx_data;
        need_d    = arg_count(rx_data);
        arg_idx_d = 1'b0;
        timer_d   = '0;
        state_d   = (arg_count(rx_data) == 2'd0) ? ST_EXEC : ST_ARGS;
      end
      ST_ARGS: begin
        if (rx_ready) begin
          args_d[arg_idx_q] = rx_data;
          timer_d           = '0;
          if ({1'b0, arg_idx_q} + 2'd1 == need_q) state_d = ST_EXEC;
          else arg_idx_d = 1'b1;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (op_q)
          OP_VERSION, OP_READ: begin
            // single-byte replies reuse the snapshot's byte 0 as the send buffer
            snap_d      = '0;
            snap_d[7:0] = (op_q == OP_VERSION) ? VERSION : reg_rd;
            seq_start   = 1'b1;
            seq_count   = CW'(1);
            state_d     = ST_TX_WAIT;
          end
          OP_WRITE:
            for (int i = 0; i < NREGS; i++)
              if (int'(args_q[0]) == i) regs_d[i*8 +: 8] = args_q[1];
          OP_TOGGLE:
            for (int i = 0; i < NFLAGS; i++)
              if (int'(args_q[0]) == i) flags_d[i] = ~flags_q[i];
          OP_DUMP: begin
            hist_reset_d = 1'b1;
            state_d      = ST_SNAP;
          end
          OP_PLL:     update_pll_d = 1'b1;
          OP_CLR_ERR: err_d        = 1'b0;
          default:    ;
        endcase
      end
      ST_SNAP: begin
        snap_d    = hist_in;
        seq_start = 1'b1;
        seq_count = CW'(NBYTES);
        state_d   = ST_TX_WAIT;
      end
      ST_TX_WAIT:  if (!tx_busy) state_d = ST_TX_PULSE;
      ST_TX_PULSE: state_d = seq_done ? ST_IDLE : ST_TX_WAIT;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= 8'h00;
      need_q       <= 2'd0;
      arg_idx_q    <= 1'b0;
      args_q       <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      regs_q       <= REG_INIT;
      flags_q      <= '0;
      snap_q       <= '0;
      hist_reset_q <= 1'b0;
      update_pll_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      need_q       <= need_d;
      arg_idx_q    <= arg_idx_d;
      args_q       <= args_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      regs_q       <= regs_d;
      flags_q      <= flags_d;
      snap_q       <= snap_d;
      hist_reset_q <= hist_reset_d;
      update_pll_q <= update_pll_d;
    end
  end

  byte_tx_seq #(.CW(CW)) u_tx_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (seq_start),
    .count     (seq_count),
    .byte_data (snap_q[int'(seq_index)*8 +: 8]),
    .tx_busy   (tx_busy),
    .index     (seq_index),
    .done      (seq_done),
    .tx_start  (tx_start),
    .tx_data   (tx_data)
  );

  assign hist_reset  = hist_reset_q;
  assign update_pll  = update_pll_q;
  assign err_timeout = err_q;
  assign regs_out    = regs_q;
  assign flags_out   = flags_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cmd_processor_p.sv
// Bench for cmd_processor_p: command vector table plus dump, timeout and reset-abort sequences.
module tb_cmd_processor_p;
  import cmd_proc_pkg::*;

  localparam int NREGS  = 8;
  localparam int NFLAGS = 8;
  localparam int NWORDS = 34;
  localparam int NBYTES = NWORDS * 4;
  localparam int NVEC   = 14;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 rx_ready;
  logic [7:0]           rx_data;
  logic                 tx_busy;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic [NWORDS*32-1:0] hist_in;
  logic                 hist_reset;
  logic [NREGS*8-1:0]   regs_out;
  logic [NFLAGS-1:0]    flags_out;
  logic                 update_pll;
  logic                 err_timeout;
  state_t               dbg_state;

  cmd_processor_p #(.TIMEOUT(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .hist_in     (hist_in),
    .hist_reset  (hist_reset),
    .regs_out    (regs_out),
    .flags_out   (flags_out),
    .update_pll  (update_pll),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    bit         has_rep;
    logic [7:0] rep;
    logic [7:0] flags;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  bit         stall_en  = 1'b0;
  int         busy_cnt  = 0;
  int         tx_cnt    = 0;
  int         hr_cycles = 0;
  int         up_cycles = 0;
  logic [7:0] first_b   = 8'h00;
  logic [7:0] last_b    = 8'h00;
  logic [7:0] mregs[NREGS];
  logic [31:0] hw[NWORDS];
  vec_t       vecs[NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor and tx_busy generator
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (hist_reset) hr_cycles++;
      if (update_pll) up_cycles++;
      if (busy_cnt > 0) busy_cnt--;
      if (tx_start) begin
        if (tx_cnt == 0) first_b = tx_data;
        last_b = tx_data;
        tx_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tx: got byte 0x%0h, expected no transmission", tx_data);
        end else begin
          check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
        end
        if (stall_en) busy_cnt = 5;
      end
      tx_busy = (busy_cnt > 0);
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); #1;
    rx_ready = 1'b1;
    rx_data  = b;
    @(negedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (dbg_state != ST_IDLE && c < budget);
    #1;
    check({name, "_idle"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  function automatic logic [63:0] model_regs();
    logic [63:0] r = '0;
    for (int i = 0; i < NREGS; i++) r[i*8 +: 8] = mregs[i];
    return r;
  endfunction

  task automatic check_reset_values(input string name);
    check({name, "_tx_start"},   64'(tx_start),    64'(0));
    check({name, "_tx_data"},    64'(tx_data),     64'(0));
    check({name, "_hist_reset"}, 64'(hist_reset),  64'(0));
    check({name, "_update_pll"}, 64'(update_pll),  64'(0));
    check({name, "_err"},        64'(err_timeout), 64'(0));
    check({name, "_regs"},       64'(regs_out),    64'(0));
    check({name, "_flags"},      64'(flags_out),   64'(0));
    check({name, "_state"},      64'(dbg_state),   64'(ST_IDLE));
  endtask

  initial begin
    int c;
    reset    = 1'b1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    hist_in  = '0;
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;

    vecs[0]  = '{1, 8'h00, 8'h00, 8'h00, 1'b1, 8'h18, 8'h00};
    vecs[1]  = '{3, 8'h01, 8'h03, 8'hA5, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{2, 8'h02, 8'h03, 8'h00, 1'b1, 8'hA5, 8'h00};
    vecs[3]  = '{3, 8'h01, 8'h09, 8'h55, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{2, 8'h02, 8'h09, 8'h00, 1'b1, 8'h00, 8'h00};
    vecs[5]  = '{2, 8'h02, 8'h03, 8'h00, 1'b1, 8'hA5, 8'h00};
    vecs[6]  = '{3, 8'h01, 8'h00, 8'h3C, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{2, 8'h02, 8'h00, 8'h00, 1'b1, 8'h3C, 8'h00};
    vecs[8]  = '{2, 8'h03, 8'h02, 8'h00, 1'b0, 8'h00, 8'h04};
    vecs[9]  = '{2, 8'h03, 8'h02, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{2, 8'h03, 8'h08, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[11] = '{2, 8'h03, 8'h05, 8'h00, 1'b0, 8'h00, 8'h20};
    vecs[12] = '{1, 8'h07, 8'h00, 8'h00, 1'b0, 8'h00, 8'h20};
    vecs[13] = '{2, 8'h02, 8'h07, 8'h00, 1'b1, 8'h00, 8'h20};

    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      if (vecs[v].has_rep) exp_q.push_back(vecs[v].rep);
      send_byte(vecs[v].b0);
      if (vecs[v].n > 1) send_byte(vecs[v].b1);
      if (vecs[v].n > 2) send_byte(vecs[v].b2);
      if (vecs[v].b0 == 8'h01 && vecs[v].b1 < 8'(NREGS)) mregs[vecs[v].b1] = vecs[v].b2;
      wait_idle($sformatf("vec%0d", v), 50);
      check($sformatf("vec%0d_regs", v),  regs_out,         model_regs());
      check($sformatf("vec%0d_flags", v), 64'(flags_out),   64'(vecs[v].flags));
      check($sformatf("vec%0d_reply", v), 64'(exp_q.size()), 64'(0));
    end
    check("reg3_a5", 64'(regs_out[31:24]), 64'(8'hA5));

    // PLL pulse width
    up_cycles = 0;
    send_byte(8'h0D);
    wait_idle("pll", 20);
    repeat (2) @(negedge clk);
    #1;
    check("pll_pulse_cycles", 64'(up_cycles), 64'(1));

    // histogram dump with tx_busy stalls
    for (int k = 0; k < NWORDS; k++) hw[k] = $urandom;
    hw[0]        = 32'h04030201;
    hw[NWORDS-1] = 32'hDEADBEEF;
    for (int k = 0; k < NWORDS; k++) hist_in[k*32 +: 32] = hw[k];
    for (int k = 0; k < NWORDS; k++)
      for (int b = 0; b < 4; b++) exp_q.push_back(hw[k][b*8 +: 8]);
    stall_en  = 1'b1;
    tx_cnt    = 0;
    hr_cycles = 0;
    send_byte(8'h0A);
    wait_idle("dump", NBYTES * 12);
    check("dump_bytes",      64'(tx_cnt),       64'(NBYTES));
    check("dump_hist_reset", 64'(hr_cycles),    64'(1));
    check("dump_first",      64'(first_b),      64'(8'h01));
    check("dump_last",       64'(last_b),       64'(8'hDE));
    check("dump_drained",    64'(exp_q.size()), 64'(0));
    stall_en = 1'b0;
    repeat (8) @(negedge clk);

    // argument timeout
    send_byte(8'h01);
    send_byte(8'h02);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!err_timeout && c < 200);
    check("timeout_cycle", 64'(c),         64'(100));
    check("timeout_state", 64'(dbg_state), 64'(ST_IDLE));
    exp_q.push_back(8'h18);
    send_byte(8'h00);
    wait_idle("post_timeout_ver", 50);
    check("post_timeout_reply", 64'(exp_q.size()), 64'(0));
    check("err_sticky",         64'(err_timeout),   64'(1));
    send_byte(8'h0E);
    wait_idle("clr_err", 20);
    check("err_cleared", 64'(err_timeout), 64'(0));

    // reset in the middle of a dump
    send_byte(8'h03);
    send_byte(8'h02);
    wait_idle("pre_abort_toggle", 20);
    send_byte(8'h01);
    repeat (110) @(negedge clk);
    check("abort_err_set", 64'(err_timeout), 64'(1));
    for (int k = 0; k < NWORDS; k++)
      for (int b = 0; b < 4; b++) exp_q.push_back(hw[k][b*8 +: 8]);
    tx_cnt = 0;
    send_byte(8'h0A);
    c = 0;
    do begin
      @(negedge clk); #1;
      c++;
    end while (tx_cnt < 50 && c < 1000);
    check("abort_at_50", 64'(tx_cnt), 64'(50));
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk); #1;
    check_reset_values("abort");
    reset = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("abort_no_more_tx", 64'(tx_cnt), 64'(50));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_processor_p.md
CMD_PROCESSOR_P -- requirements
Module: cmd_processor_p

Interface
REQ-001 SHALL have parameter VERSION, default 8'd24, the firmware version byte returned by opcode 0x00.
REQ-002 SHALL have parameter NREGS, default 8, the number of byte-wide config registers.
REQ-003 SHALL have parameter NFLAGS, default 8, the number of toggle flag bits.
REQ-004 SHALL have parameter NWORDS, default 34, the number of 32-bit histogram words dumped.
REQ-005 SHALL have parameter REG_INIT, default all zero, the NREGS*8-bit reset image of the registers.
REQ-006 SHALL have parameter TIMEOUT, default 50_000_000, the maximum wait in cycles for an argument byte.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port rx_ready, input, 1 bit: rx_data is valid this cycle.
REQ-010 SHALL have port rx_data, input, 8 bits: received byte.
REQ-011 SHALL have port tx_busy, input, 1 bit: the transmitter is busy.
REQ-012 SHALL have port tx_start, output, 1 bit: one-cycle send strobe.
REQ-013 SHALL have port tx_data, output, 8 bits: byte to send, held stable while tx_start is high.
REQ-014 SHALL have port hist_in, input, NWORDS*32 bits: live histogram words, word k at [32k+31:32k].
REQ-015 SHALL have port hist_reset, output, 1 bit: one-cycle pulse telling the histogram to clear.
REQ-016 SHALL have port regs_out, output, NREGS*8 bits: config registers, register i at [8i+7:8i].
REQ-017 SHALL have port flags_out, output, NFLAGS bits: toggle flags.
REQ-018 SHALL have port update_pll, output, 1 bit: one-cycle PLL update pulse.
REQ-019 SHALL have port err_timeout, output, 1 bit: sticky flag, set on argument timeout.

Function
REQ-020 SHALL implement states IDLE, ARGS, EXEC, SNAP, TX_WAIT and TX_PULSE.
REQ-021 SHALL, in IDLE with rx_ready high, latch rx_data as the opcode and go to ARGS if the opcode needs arguments, otherwise to EXEC.
REQ-022 SHALL use these argument counts: 0x01=2, 0x02=1, 0x03=1, all other opcodes 0.
REQ-023 SHALL, in ARGS, store each byte that arrives with rx_ready into the next argument slot and enter EXEC in the cycle after the last argument byte.
REQ-024 SHALL reload the ARGS cycle counter on each byte received; when the counter reaches TIMEOUT it SHALL set err_timeout, discard the command and return to IDLE.
REQ-025 SHALL execute opcode 0x00 by sending 1 byte, VERSION.
REQ-026 SHALL execute opcode 0x01 as regs[arg0] <= arg1, with no reply; if arg0 >= NREGS nothing is written.
REQ-027 SHALL execute opcode 0x02 by sending 1 byte, regs[arg0], or 8'h00 if arg0 >= NREGS.
REQ-028 SHALL execute opcode 0x03 as flags[arg0] <= ~flags[arg0]; if arg0 >= NFLAGS nothing changes.
REQ-029 SHALL execute opcode 0x0A by going to SNAP, capturing all of hist_in into a snapshot in that cycle, and pulsing hist_reset high in that same cycle only.
REQ-030 SHALL, after a 0x0A capture, send NWORDS*4 bytes from the snapshot, word 0 first, each word least-significant byte first.
REQ-031 SHALL execute opcode 0x0D by pulsing update_pll for exactly 1 cycle and returning to IDLE.
REQ-032 SHALL execute opcode 0x0E by clearing err_timeout.
REQ-033 SHALL treat any other opcode as a no-op and return to IDLE.
REQ-034 SHALL, in TX_WAIT with tx_busy low, drive tx_data and assert tx_start for 1 cycle, then go to TX_PULSE.
REQ-035 SHALL, in TX_PULSE, deassert tx_start, advance the byte index, and go to TX_WAIT, or to IDLE after the last byte.
REQ-036 SHALL ignore tx_busy in the cycle tx_start is asserted.
REQ-037 SHALL ignore rx_ready in EXEC, SNAP, TX_WAIT and TX_PULSE; bytes arriving there are dropped.
REQ-038 SHALL ensure hist_reset and update_pll are never high for more than 1 consecutive cycle.
REQ-039 SHALL keep the byte index wide enough for NWORDS*4 bytes with no wrap before the last byte.
REQ-040 SHALL apply reset above all else: if reset is high in the same cycle as rx_ready or a transmit, reset wins.

Reset
REQ-041 SHALL, on reset, set state to IDLE, tx_start=0, tx_data=0, hist_reset=0, update_pll=0, err_timeout=0, regs=REG_INIT, flags=0, and clear the argument slots and counters.
REQ-042 SHALL, on reset in mid-transmit, abort the transfer with no further tx_start; the snapshot contents may be left stale.

Structure
REQ-043 SHALL place the opcode constants, argument-count table and state enum in shared package cmd_proc_pkg.
REQ-044 SHALL implement TX_WAIT/TX_PULSE byte sequencing as sub-module byte_tx_seq, with inputs start, count and byte and outputs index, done, tx_start and tx_data.

Verification
REQ-045 SHALL verify: rx 0x00 -> exactly 1 tx_start with tx_data=0x18, then IDLE.
REQ-046 SHALL verify: rx 0x01,0x03,0xA5 then 0x02,0x03 -> regs_out[31:24]=0xA5 and a reply of 0xA5; 0x01,0x09,0x55 -> regs unchanged.
REQ-047 SHALL verify: hist_in word0=0x04030201, word33=0xDEADBEEF, rx 0x0A -> 1 hist_reset pulse and 136 bytes, first 01 02 03 04, last EF BE AD DE; tx_busy held high for 5 cycles between bytes stalls without loss.
REQ-048 SHALL verify, with TIMEOUT=100: rx 0x01,0x02 then silence -> err_timeout=1 at cycle 100 and IDLE; a following 0x00 replies 0x18; 0x0E clears err_timeout.
REQ-049 SHALL verify: reset asserted at byte 50 of a 0x0A dump -> tx_start stays low and all outputs take their reset values the next cycle.
REQ-050 SHALL verify: rx 0x03,0x02 twice -> flags_out[2] goes 0->1->0; rx 0x0D -> update_pll high for exactly 1 cycle.
